cpu_fetch: RTL and testbench
============================

# cpu_fetch

Instruction fetch stage of the CPU pipeline. It owns the program counter and drives the instruction cache's fetch-address and stall inputs. It consumes the cache's single-cycle `ready`/`rdata` pulse and presents one registered instruction/PC pair to decode through a valid/ready handshake. Fetch does not speculate: it stops after any control-flow instruction and resumes only on a redirect from execute. It also guarantees that the fetch address never changes while a cache access is in flight.

## Interface
- `RESET_PC`, default 32'h00000000: PC loaded on reset.
- `i_clock`  in  1  clock; all state updates on the rising edge.
- `i_reset`  in  1  reset; synchronous, active-high.
- `o_icache_pc`  out  32  fetch address to the instruction cache; always equals internal `pc`.
- `o_icache_stall`  out  1  holds the cache idle.
- `i_icache_ready`  in  1  one-cycle pulse; `i_icache_rdata` is valid for `o_icache_pc`.
- `i_icache_rdata`  in  32  fetched instruction word.
- `i_redirect`  in  1  one-cycle pulse from execute; resolves a control-flow instruction.
- `i_redirect_pc`  in  32  target PC: taken target, or pc+4 for a not-taken branch.
- `o_valid`  out  1  output register holds an instruction.
- `i_ready`  in  1  decode accepts the output register this cycle.
- `o_pc`  out  32  PC of `o_instruction`.
- `o_instruction`  out  32  instruction word.

## Operation
- **State machine:** `FETCH`, `WAIT_BRANCH`.
  - Reset state is `FETCH`, with `pc=RESET_PC`, `o_valid=0`, `o_pc=0`, `o_instruction=0`, `inflight=0`, `pending=0`.
- **Cache stall:** `o_icache_stall = (state==WAIT_BRANCH) || (o_valid && !i_ready) || pending`.
  - Exception: while `inflight=1`, stall is 0 whatever the other terms are, because the cache's fill path ignores stall.
- **In-flight tracking:**
  - `inflight` sets on any cycle with `o_icache_stall=0` and `i_icache_ready=0`.
  - It clears on `i_icache_ready`.
  - While `inflight=1`, `pc` must not change.
- **Accept:** when `i_icache_ready=1` and `pending=0`:
  - Load `o_instruction<=i_icache_rdata` and `o_pc<=pc`, and set `o_valid<=1`.
  - Then `pc<=pc+4`, which wraps modulo 2^32.
- **Control flow:** an accepted word with `opcode[6:0]` equal to 7'b1100011 (BRANCH), 7'b1101111 (JAL) or 7'b1100111 (JALR) moves the FSM to `WAIT_BRANCH`. In that case `pc` is not incremented.
- **Handshake:**
  - `o_valid` clears on `i_ready && o_valid` unless a new word is accepted in the same cycle.
  - A new word may be accepted in the same cycle that decode consumes the current one, giving back-to-back throughput.
- **Redirect in `WAIT_BRANCH`:** `pc<=i_redirect_pc` and state becomes `FETCH`.
  - `o_valid` is untouched; the branch itself may still be unconsumed.
- **Redirect in `FETCH`** (trap or flush):
  - If `inflight=0`: `pc<=i_redirect_pc` and `o_valid<=0`.
  - If `inflight=1`: store `pending_pc<=i_redirect_pc`, set `pending<=1` and `o_valid<=0`.
  - When the cache `ready` later arrives, the word is discarded, `pc<=pending_pc` and `pending<=0`.
- **Redirect with `i_icache_ready` in the same cycle:** the redirect wins.
  - The word is discarded and `pc<=i_redirect_pc`.
- **Redirect target alignment:** `i_redirect_pc[1:0]` is forced to 0.
- **Reset mid-operation:** state returns to the reset values above within one edge.
  - An in-flight cache fill is abandoned; the cache is reset by the same `i_reset`.

## Timing
- The cache sees the new `pc` in the cycle after accept or redirect, since `pc` is registered.
- Hit path: `o_valid` rises 1 cycle after `i_icache_ready`. Sustained throughput is one instruction per cache-ready pulse.
- Redirect to the first new cache request: the redirect edge, then `o_icache_stall=0` with the new `pc` on the next cycle.
- The first cycle after reset deassertion drives `o_icache_pc=RESET_PC` and `o_icache_stall=0`.
- No combinational path from `i_icache_rdata` to any output.
- `o_icache_stall` depends combinationally on `i_ready`.

## Test plan
- **Reset and sequential fetch:** `RESET_PC=0x100`, cache returns 0x00000013 (NOP) for every address, `i_ready=1`.
  - `o_pc` must read 0x100, 0x104, 0x108 on consecutive ready pulses, each with `o_instruction=0x13`.
- **Decode backpressure:** hold `i_ready=0` for 5 cycles after `o_valid`.
  - `o_icache_stall` must stay 1 and `o_pc` must hold.
  - On release, the next `o_pc` is +4 with no word lost or duplicated.
- **Branch stall:** fetch 0x00000063 (BEQ) at 0x200.
  - The FSM must enter `WAIT_BRANCH` and `o_icache_stall` must stay 1.
  - Then `i_redirect=1` with `i_redirect_pc=0x300`: the next `o_pc` is 0x300.
- **Redirect during a miss:** assert `i_redirect` to 0x400 while the cache is filling from 0x120 (ready pulses 6 cycles later).
  - `o_icache_pc` must hold 0x120 until ready.
  - The 0x120 word must never reach `o_valid`, and the next request is 0x400.
- **Simultaneous ready and redirect** to 0x500.
  - The word is dropped, `o_valid=0`, and the next `o_icache_pc` is 0x500.
- **PC wrap:** `RESET_PC=0xFFFFFFFC`.
  - The second fetch address must be 0x00000000.

Source files
------------

// File: rtl/cpu_fetch.sv
// Instruction fetch stage: owns the PC, drives the I-cache request, and holds
// one fetched instruction/PC pair for decode behind a valid/ready handshake.
module cpu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic [31:0] o_icache_pc,
  output logic        o_icache_stall,
  input  logic        i_icache_ready,
  input  logic [31:0] i_icache_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_pc,
  output logic [31:0] o_instruction
);

  typedef enum logic {
    FETCH       = 1'b0,
    WAIT_BRANCH = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic        valid_q, valid_d;
  logic        inflight_q, inflight_d;
  logic        pending_q, pending_d;
  logic        stall;
  logic        is_cf;
  logic [31:0] redirect_al;

  assign redirect_al = i_redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    is_cf = 1'b0;
    case (i_icache_rdata[6:0])
      7'b1100011, 7'b1101111, 7'b1100111: is_cf = 1'b1;
      default:                            is_cf = 1'b0;
    endcase
  end

  // The cache fill path ignores stall, so an in-flight access forces it low.
  always_comb begin
    if (inflight_q) begin
      stall = 1'b0;
    end else begin
      stall = (state_q == WAIT_BRANCH) || (valid_q && !i_ready) || pending_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    out_pc_d     = out_pc_q;
    instr_d      = instr_q;
    pending_pc_d = pending_pc_q;
    valid_d      = valid_q;
    inflight_d   = inflight_q;
    pending_d    = pending_q;

    if (i_icache_ready) begin
      inflight_d = 1'b0;
    end else if (!stall) begin
      inflight_d = 1'b1;
    end

    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

    if (state_q == WAIT_BRANCH) begin
      if (i_redirect) begin
        pc_d    = redirect_al;
        state_d = FETCH;
      end
    end else if (i_redirect) begin
      // A redirect beats a same-cycle cache word; during a fill it is deferred.
      valid_d = 1'b0;
      if (i_icache_ready || !inflight_q) begin
        pc_d      = redirect_al;
        pending_d = 1'b0;
      end else begin
        pending_pc_d = redirect_al;
        pending_d    = 1'b1;
      end
    end else if (i_icache_ready) begin
      if (pending_q) begin
        pc_d      = pending_pc_q;
        pending_d = 1'b0;
      end else begin
        instr_d  = i_icache_rdata;
        out_pc_d = pc_q;
        valid_d  = 1'b1;
        if (is_cf) begin
          state_d = WAIT_BRANCH;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      out_pc_q     <= '0;
      instr_q      <= '0;
      pending_pc_q <= '0;
      valid_q      <= 1'b0;
      inflight_q   <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      out_pc_q     <= out_pc_d;
      instr_q      <= instr_d;
      pending_pc_q <= pending_pc_d;
      valid_q      <= valid_d;
      inflight_q   <= inflight_d;
      pending_q    <= pending_d;
    end
  end

  assign o_icache_pc    = pc_q;
  assign o_icache_stall = stall;
  assign o_valid        = valid_q;
  assign o_pc           = out_pc_q;
  assign o_instruction  = instr_q;

endmodule

// File: tb/tb_cpu_fetch.sv
// Bench for cpu_fetch: a variable-latency cache model, a program-order model of
// the instruction stream decode must see, and directed scenarios.
module tb_cpu_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        ic_ready = 1'b0;
  logic [31:0] ic_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_ready = 1'b1;
  logic [31:0] ic_pc, o_pc, o_instr;
  logic        ic_stall, o_valid;

  cpu_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .i_clock(clk), .i_reset(rst),
    .o_icache_pc(ic_pc), .o_icache_stall(ic_stall),
    .i_icache_ready(ic_ready), .i_icache_rdata(ic_rdata),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_valid(o_valid), .i_ready(dec_ready),
    .o_pc(o_pc), .o_instruction(o_instr)
  );

  logic [31:0] w_icpc, w_opc, w_instr;
  logic        w_stall, w_valid;
  logic        w_busy = 1'b0, w_ready = 1'b0;

  cpu_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .i_clock(clk), .i_reset(rst),
    .o_icache_pc(w_icpc), .o_icache_stall(w_stall),
    .i_icache_ready(w_ready), .i_icache_rdata(32'h0000_0013),
    .i_redirect(1'b0), .i_redirect_pc(32'h0),
    .o_valid(w_valid), .i_ready(1'b1),
    .o_pc(w_opc), .o_instruction(w_instr)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout waiting for DUT", name);
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0000_0200: return 32'h0000_0063;
      32'h0000_030C: return 32'h0000_006F;
      32'h0000_0600: return 32'h0000_0067;
      default:       return (a < 32'h200) ? 32'h0000_0013 : {a[26:2], 7'h13};
    endcase
  endfunction

  function automatic bit is_cf(input logic [31:0] w);
    return (w[6:0] == 7'h63) || (w[6:0] == 7'h6F) || (w[6:0] == 7'h67);
  endfunction

  // Cache: accepts an address on a non-stalled cycle, answers after lat cycles.
  int unsigned lat = 1;
  int unsigned cnt = 0;
  logic        busy = 1'b0;
  logic [31:0] caddr = '0;

  always @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      ic_ready <= 1'b0;
    end else if (ic_ready) begin
      ic_ready <= 1'b0;
    end else if (busy) begin
      if (cnt <= 1) begin
        busy     <= 1'b0;
        ic_ready <= 1'b1;
        ic_rdata <= mem(caddr);
      end else begin
        cnt <= cnt - 1;
      end
    end else if (!ic_stall) begin
      busy  <= 1'b1;
      caddr <= ic_pc;
      cnt   <= lat;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      w_busy  <= 1'b0;
      w_ready <= 1'b0;
    end else if (w_ready) begin
      w_ready <= 1'b0;
    end else if (w_busy) begin
      w_busy  <= 1'b0;
      w_ready <= 1'b1;
    end else if (!w_stall) begin
      w_busy <= 1'b1;
    end
  end

  // Program-order model: next PC decode must receive, and redirect handling.
  logic [31:0] exp_pc = 32'h100;
  logic [31:0] br_target = '0;
  logic [31:0] prev_pc = '0;
  logic        prev_hold = 1'b0;
  logic        flush_flag = 1'b0;
  logic [31:0] got[$];
  logic [31:0] got_instr[$];
  logic [31:0] w_got[$];

  always begin
    @(negedge clk);
    #4;
    if (rst) begin
      exp_pc    = 32'h100;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", {31'b0, o_valid}, 32'd1);
        chk("hold_pc", o_pc, prev_pc);
      end
      if (busy || ic_ready) begin
        chk("inflight_stall", {31'b0, ic_stall}, 32'd0);
        chk("inflight_pc", ic_pc, caddr);
      end else if (o_valid && !dec_ready) begin
        chk("held_stall", {31'b0, ic_stall}, 32'd1);
      end
      if (o_valid && dec_ready) begin
        chk("hs_pc", o_pc, exp_pc);
        chk("hs_instr", o_instr, mem(exp_pc));
        got.push_back(o_pc);
        got_instr.push_back(o_instr);
        exp_pc = is_cf(mem(exp_pc)) ? br_target : exp_pc + 32'd4;
      end
      if (redirect && flush_flag) exp_pc = redirect_pc & 32'hFFFF_FFFC;
      prev_hold = o_valid && !dec_ready && !(redirect && flush_flag);
      prev_pc   = o_pc;
      if (w_valid) w_got.push_back(w_opc);
    end
  end

  task automatic wait_hs(input int n, input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (got.size() >= n) return;
    end
    timeout_fail(name);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (o_valid) return;
    end
    timeout_fail(name);
  endtask

  task automatic wait_valid_pc(input logic [31:0] pc, input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (o_valid && o_pc == pc) return;
    end
    timeout_fail(name);
  endtask

  task automatic wait_busy(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy) return;
    end
    timeout_fail(name);
  endtask

  task automatic wait_ic_ready(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ic_ready) return;
    end
    timeout_fail(name);
  endtask

  // Hold the current output, then flush to target (fetch is idle, stall=1).
  task automatic held_flush(input logic [31:0] target, input string name);
    wait_valid(name);
    dec_ready   = 1'b0;
    flush_flag  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = target;
    @(negedge clk);
    redirect  = 1'b0;
    dec_ready = 1'b1;
  endtask

  logic [31:0] p;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_opc", o_pc, 32'h0);
    chk("rst_instr", o_instr, 32'h0);
    chk("rst_icpc", ic_pc, 32'h100);
    rst = 1'b0;
    #1;
    chk("first_icpc", ic_pc, 32'h100);
    chk("first_stall", {31'b0, ic_stall}, 32'd0);
    chk("wrap_first_icpc", w_icpc, 32'hFFFF_FFFC);

    // Sequential fetch.
    wait_hs(3, "seq");
    if (got.size() >= 3) begin
      chk("seq_pc0", got[0], 32'h100);
      chk("seq_pc1", got[1], 32'h104);
      chk("seq_pc2", got[2], 32'h108);
      chk("seq_instr2", got_instr[2], 32'h13);
    end

    // Decode backpressure.
    wait_valid("bp_valid");
    p = o_pc;
    dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_stall", {31'b0, ic_stall}, 32'd1);
      chk("bp_pc", o_pc, p);
      @(negedge clk);
    end
    dec_ready = 1'b1;
    got.delete();
    wait_hs(2, "bp_release");
    if (got.size() >= 2) begin
      chk("bp_rel0", got[0], p);
      chk("bp_rel1", got[1], p + 32'd4);
    end

    // Redirect during a miss from 0x120.
    lat = 6;
    held_flush(32'h120, "miss_setup");
    wait_busy("miss_busy");
    chk("miss_addr", caddr, 32'h120);
    repeat (2) @(negedge clk);
    flush_flag  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h400;
    @(negedge clk);
    redirect = 1'b0;
    wait_ic_ready("miss_ready");
    @(negedge clk);
    #1;
    chk("miss_next_icpc", ic_pc, 32'h400);
    chk("miss_next_stall", {31'b0, ic_stall}, 32'd0);
    chk("miss_dropped", {31'b0, o_valid}, 32'd0);
    lat = 1;
    got.delete();
    wait_hs(1, "miss_resume");
    if (got.size() >= 1) chk("miss_first", got[0], 32'h400);

    // Ready and redirect in the same cycle.
    lat = 3;
    wait_ic_ready("sim_ready");
    flush_flag  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h500;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("sim_valid", {31'b0, o_valid}, 32'd0);
    chk("sim_icpc", ic_pc, 32'h500);
    lat = 1;
    got.delete();
    wait_hs(1, "sim_resume");
    if (got.size() >= 1) chk("sim_first", got[0], 32'h500);

    // Branch at 0x200 waits for resolution.
    br_target = 32'h300;
    held_flush(32'h200, "br_setup");
    wait_valid_pc(32'h200, "br_fetch");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("br_stall", {31'b0, ic_stall}, 32'd1);
      chk("br_icpc", ic_pc, 32'h200);
    end
    flush_flag  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("br_new_icpc", ic_pc, 32'h300);
    chk("br_new_stall", {31'b0, ic_stall}, 32'd0);

    // JAL resolved while still unconsumed, with an unaligned target.
    br_target = 32'h600;
    wait_valid_pc(32'h30C, "jal_fetch");
    dec_ready   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h602;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("jal_kept_valid", {31'b0, o_valid}, 32'd1);
    chk("jal_kept_pc", o_pc, 32'h30C);
    chk("jal_aligned_icpc", ic_pc, 32'h600);
    dec_ready = 1'b1;
    wait_valid_pc(32'h600, "jalr_fetch");
    br_target   = 32'h640;
    redirect    = 1'b1;
    redirect_pc = 32'h640;
    @(negedge clk);
    redirect = 1'b0;
    got.delete();
    wait_hs(2, "jalr_resume");
    if (got.size() >= 2) begin
      chk("jalr_first", got[0], 32'h640);
      chk("jalr_second", got[1], 32'h644);
    end

    // Reset in the middle of a fill.
    lat = 4;
    wait_busy("rst_busy");
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_valid", {31'b0, o_valid}, 32'd0);
    chk("mid_rst_opc", o_pc, 32'h0);
    chk("mid_rst_instr", o_instr, 32'h0);
    chk("mid_rst_icpc", ic_pc, 32'h100);
    rst = 1'b0;
    lat = 1;
    got.delete();
    wait_hs(1, "rst_resume");
    if (got.size() >= 1) chk("rst_first", got[0], 32'h100);

    // PC wrap on the second instance (its first two outputs precede the reset above).
    if (w_got.size() >= 2) begin
      chk("wrap_pc0", w_got[0], 32'hFFFF_FFFC);
      chk("wrap_pc1", w_got[1], 32'h0000_0000);
    end else begin
      timeout_fail("wrap_outputs");
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
